pipeline_hazard_controller: RTL and testbench



---
 rtl/pipeline_hazard_controller_if.sv | 56 +++++
 rtl/pipeline_hazard_controller.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Bundles the hazard-detection inputs and the stall/flush control outputs
// exchanged between the pipeline datapath and the hazard controller.
//
//   ID/EX view : idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable
//   MEM view   : memRedirect, memAccessValid, memReady
//   controls   : pcWriteEnable, <reg>WriteEnable, <reg>Flush (reg = ifId,
//                idEx, exMem, memWb)
//   status     : memTimeout, stallCount, flushCount
//
// modport master : the hazard controller (drives controls and status)
// modport slave  : the pipeline datapath (drives hazard inputs)
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int COUNT_WIDTH = 32
);
  logic [4:0]             idRs1;
  logic [4:0]             idRs2;
  logic                   idUsesRs1;
  logic                   idUsesRs2;
  logic [4:0]             exRd;
  logic                   exMemoryReadEnable;
  logic                   memRedirect;
  logic                   memAccessValid;
  logic                   memReady;

  logic                   pcWriteEnable;
  logic                   ifIdWriteEnable;
  logic                   idExWriteEnable;
  logic                   exMemWriteEnable;
  logic                   memWbWriteEnable;
  logic                   ifIdFlush;
  logic                   idExFlush;
  logic                   exMemFlush;
  logic                   memWbFlush;
  logic                   memTimeout;
  logic [COUNT_WIDTH-1:0] stallCount;
  logic [COUNT_WIDTH-1:0] flushCount;

  modport master (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable,
           memRedirect, memAccessValid, memReady,
    output pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable,
           memWbWriteEnable, ifIdFlush, idExFlush, exMemFlush, memWbFlush,
           memTimeout, stallCount, flushCount
  );

  modport slave (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemoryReadEnable,
           memRedirect, memAccessValid, memReady,
    input  pcWriteEnable, ifIdWriteEnable, idExWriteEnable, exMemWriteEnable,
           memWbWriteEnable, ifIdFlush, idExFlush, exMemFlush, memWbFlush,
           memTimeout, stallCount, flushCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Resolves
// memory-wait stalls, MEM-stage redirects and load-use hazards (in that
// priority order) into write-enable / flush controls for the PC and the four
// pipeline registers. A memory wait lasting MEM_TIMEOUT stalled cycles parks
// the controller in FAULT until reset.
//
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   hz     : controller side of pipeline_hazard_controller_if
//            (hazard inputs in, controls/memTimeout/counters out)
// Controls are combinational so they act in the cycle the hazard is seen;
// state, wait counter, memTimeout and the performance counters are flops.
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  pipeline_hazard_controller_if.master  hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [7:0]             WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [7:0]             wait_count_q, wait_count_d;
  logic                   mem_timeout_q, mem_timeout_d;
  logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [COUNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic active_s;
  logic mem_stall_s;
  logic redirect_s;
  logic rs_hit_s;
  logic load_use_s;

  // Hazard detection with priority memStall > redirect > loadUse.
  always_comb begin
    active_s    = 1'b0;
    mem_stall_s = 1'b0;
    redirect_s  = 1'b0;
    rs_hit_s    = 1'b0;
    load_use_s  = 1'b0;
    if (!reset && (state_q != FAULT)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    rs_hit_s    = (hz.idUsesRs1 && (hz.idRs1 == hz.exRd)) ||
                  (hz.idUsesRs2 && (hz.idRs2 == hz.exRd));
    mem_stall_s = active_s && hz.memAccessValid && !hz.memReady;
    redirect_s  = active_s && hz.memRedirect && !mem_stall_s;
    // x0 is hard-wired zero, so a load "writing" it never creates a hazard.
    load_use_s  = active_s && hz.exMemoryReadEnable && (hz.exRd != 5'd0) &&
                  rs_hit_s && !mem_stall_s && !redirect_s;
  end

  // Pipeline register enables and flushes for the current cycle.
  always_comb begin
    hz.pcWriteEnable    = 1'b0;
    hz.ifIdWriteEnable  = 1'b0;
    hz.idExWriteEnable  = 1'b0;
    hz.exMemWriteEnable = 1'b0;
    hz.memWbWriteEnable = 1'b0;
    hz.ifIdFlush        = 1'b0;
    hz.idExFlush        = 1'b0;
    hz.exMemFlush       = 1'b0;
    hz.memWbFlush       = 1'b0;
    if (active_s) begin
      hz.pcWriteEnable    = 1'b1;
      hz.ifIdWriteEnable  = 1'b1;
      hz.idExWriteEnable  = 1'b1;
      hz.exMemWriteEnable = 1'b1;
      hz.memWbWriteEnable = 1'b1;
      if (mem_stall_s) begin
        // Freeze everything upstream of MEM; WB receives a bubble.
        hz.pcWriteEnable    = 1'b0;
        hz.ifIdWriteEnable  = 1'b0;
        hz.idExWriteEnable  = 1'b0;
        hz.exMemWriteEnable = 1'b0;
        hz.memWbFlush       = 1'b1;
      end else if (redirect_s) begin
        // Squash the three younger instructions; PC takes the target.
        hz.ifIdFlush  = 1'b1;
        hz.idExFlush  = 1'b1;
        hz.exMemFlush = 1'b1;
      end else if (load_use_s) begin
        // Hold PC and IF/ID, insert one bubble into EX.
        hz.pcWriteEnable   = 1'b0;
        hz.ifIdWriteEnable = 1'b0;
        hz.idExFlush       = 1'b1;
      end else begin
        hz.ifIdFlush = 1'b0;
      end
    end else begin
      hz.pcWriteEnable = 1'b0;
    end
  end

  // Next-state, wait counter, sticky timeout and saturating counters.
  always_comb begin
    state_d       = state_q;
    wait_count_d  = wait_count_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          state_d      = MEM_WAIT;
          wait_count_d = 8'd1;
        end else begin
          wait_count_d = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall_s) begin
          state_d      = RUN;
          wait_count_d = 8'd0;
        end else if (wait_count_q == WAIT_LAST) begin
          // This cycle is the MEM_TIMEOUT-th consecutive stalled cycle.
          state_d       = FAULT;
          mem_timeout_d = 1'b1;
        end else begin
          wait_count_d = wait_count_q + 8'd1;
        end
      end
      FAULT: begin
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d      = RUN;
        wait_count_d = 8'd0;
      end
    endcase
    if ((mem_stall_s || load_use_s) && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
    if (redirect_s && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      wait_count_q  <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= {COUNT_WIDTH{1'b0}};
      flush_count_q <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      wait_count_q  <= wait_count_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.memTimeout = mem_timeout_q;
  assign hz.stallCount = stall_count_q;
  assign hz.flushCount = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Directed hazard scenarios followed by randomized traffic, every cycle
// compared against a behavioural model that tracks "consecutive stalled
// cycles", a fault flag and plain integer counters.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;
  localparam int MEM_TIMEOUT = 4;
  localparam int COUNT_WIDTH = 5;
  localparam int CNT_MAX     = (1 << COUNT_WIDTH) - 1;

  logic clock;
  logic reset;

  pipeline_hazard_controller_if #(.COUNT_WIDTH(COUNT_WIDTH)) hz_if ();

  pipeline_hazard_controller #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;

  // model state
  bit m_fault;
  int m_consec;
  int m_stalls;
  int m_flushes;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model.
  task automatic apply(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic rdr, input logic mav,
                       input logic mrdy);
    bit live, ms, rj, lu;
    logic [8:0] exp_ctl, obs_ctl;
    @(negedge clock);
    reset                    = rst;
    hz_if.idRs1              = rs1;
    hz_if.idRs2              = rs2;
    hz_if.idUsesRs1          = u1;
    hz_if.idUsesRs2          = u2;
    hz_if.exRd               = rd;
    hz_if.exMemoryReadEnable = ld;
    hz_if.memRedirect        = rdr;
    hz_if.memAccessValid     = mav;
    hz_if.memReady           = mrdy;
    #1;
    live = !rst && !m_fault;
    ms   = live && mav && !mrdy;
    rj   = live && rdr && !ms;
    lu   = live && ld && (rd != 5'd0) &&
           ((u1 && rs1 == rd) || (u2 && rs2 == rd)) && !ms && !rj;
    // order: pc, ifId, idEx, exMem, memWb enables; ifId, idEx, exMem, memWb flushes
    if (!live)     exp_ctl = 9'b00000_0000;
    else if (ms)   exp_ctl = 9'b00001_0001;
    else if (rj)   exp_ctl = 9'b11111_1110;
    else if (lu)   exp_ctl = 9'b00111_0100;
    else           exp_ctl = 9'b11111_0000;
    obs_ctl = {hz_if.pcWriteEnable, hz_if.ifIdWriteEnable, hz_if.idExWriteEnable,
               hz_if.exMemWriteEnable, hz_if.memWbWriteEnable, hz_if.ifIdFlush,
               hz_if.idExFlush, hz_if.exMemFlush, hz_if.memWbFlush};
    check_val("controls", 32'(obs_ctl), 32'(exp_ctl));
    check_val("memTimeout", 32'(hz_if.memTimeout), 32'(m_fault));
    check_val("stallCount", 32'(hz_if.stallCount), 32'(m_stalls));
    check_val("flushCount", 32'(hz_if.flushCount), 32'(m_flushes));
    // model update for the coming posedge
    if (rst) begin
      m_fault = 1'b0; m_consec = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_fault) begin
      if (ms) begin
        m_consec++;
        if (m_consec >= MEM_TIMEOUT) m_fault = 1'b1;
      end else begin
        m_consec = 0;
      end
      if ((ms || lu) && m_stalls < CNT_MAX) m_stalls++;
      if (rj && m_flushes < CNT_MAX) m_flushes++;
    end
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_fault = 1'b0; m_consec = 0; m_stalls = 0; m_flushes = 0;
    reset = 1'b1;
    hz_if.idRs1 = 5'd0; hz_if.idRs2 = 5'd0; hz_if.idUsesRs1 = 1'b0;
    hz_if.idUsesRs2 = 1'b0; hz_if.exRd = 5'd0; hz_if.exMemoryReadEnable = 1'b0;
    hz_if.memRedirect = 1'b0; hz_if.memAccessValid = 1'b0; hz_if.memReady = 1'b0;

    // reset: everything low
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // load-use on rs1, then same without idUsesRs1
    apply(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check_val("lu_stallCount", 32'(hz_if.stallCount), 32'd1);
    apply(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    // x0 never stalls, then rs2 match stalls
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // redirect wins over load-use
    apply(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    check_val("rj_flushCount", 32'(hz_if.flushCount), 32'd1);
    // memory wait: 3 stalled cycles then completion
    for (int i = 0; i < 3; i++)
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    // memory wait with redirect held: flush only on completion
    for (int i = 0; i < 2; i++)
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();
    // timeout: MEM_TIMEOUT stalled cycles then FAULT
    for (int i = 0; i < MEM_TIMEOUT; i++)
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("fault_flag", 32'(hz_if.memTimeout), 32'd1);
    idle();
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check_val("post_reset_stall", 32'(hz_if.stallCount), 32'd0);

    // saturation of both counters
    for (int i = 0; i < CNT_MAX + 6; i++)
      apply(1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX + 6; i++)
      apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check_val("stall_sat", 32'(hz_if.stallCount), 32'(CNT_MAX));
    check_val("flush_sat", 32'(hz_if.flushCount), 32'(CNT_MAX));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 59) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
